// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants, FSM encoding and helpers for the PS/2 key tracker.
package ps2_kbd_pkg;

    // Prefix bytes
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    // Keyboard response / error bytes that never form a key event
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_ERR_00   = 8'h00;
    localparam logic [7:0] PS2_ERR_FF   = 8'hFF;

    // Bytes that follow E1 in the pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StE0,
        StF0,
        StE0F0,
        StSkip
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_BAT_FAIL) || (b == PS2_RESEND) || (b == PS2_ERR_00) ||
               (b == PS2_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte input / key state and event output bundle of the key tracker.
interface ps2_key_tracker_if #(
    parameter int unsigned N_KEYS = 4,
    parameter int unsigned IDXW   = 2
);
    logic [7:0]        din;
    logic              rx_done_tick;
    logic              clear_all;
    logic [N_KEYS-1:0] key_down;
    logic              any_down;
    logic              evt_valid;
    logic [7:0]        evt_code;
    logic              evt_ext;
    logic              evt_break;
    logic              evt_hit;
    logic [IDXW-1:0]   evt_idx;
    logic              evt_repeat;
    logic              err_tick;

    // Byte source / consumer side
    modport master (
        output din, rx_done_tick, clear_all,
        input  key_down, any_down, evt_valid, evt_code, evt_ext, evt_break,
               evt_hit, evt_idx, evt_repeat, err_tick
    );

    // Tracker side
    modport slave (
        input  din, rx_done_tick, clear_all,
        output key_down, any_down, evt_valid, evt_code, evt_ext, evt_break,
               evt_hit, evt_idx, evt_repeat, err_tick
    );
endinterface

// File: rtl/ps2_key_tracker_lut.sv
// Combinational {ext,code} -> {hit,idx} lookup against the configured key table.
module ps2_key_lut #(
    parameter int unsigned           N_KEYS    = 4,
    parameter logic [9*N_KEYS-1:0]   KEY_CODES = {9'h033, 9'h016, 9'h045, 9'h02C},
    parameter int unsigned           IDXW      = 2
) (
    input  logic            i_ext,
    input  logic [7:0]      i_code,
    output logic            o_hit,
    output logic [IDXW-1:0] o_idx
);

    // Scan from the top down so the lowest matching index is the one kept
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == {i_ext, i_code}) begin
                o_hit = 1'b1;
                o_idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: make/break/extended/pause sequences, held-key levels, event records.
module ps2_key_tracker
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned         N_KEYS      = 4,
    // Key i lives at [9i+8:9i]; bit 8 = extended (E0) flag
    parameter logic [9*N_KEYS-1:0] KEY_CODES   = {9'h033, 9'h016, 9'h045, 9'h02C},
    parameter int unsigned         TIMEOUT_CYC = 2_000_000,
    parameter int unsigned         IDXW        = (N_KEYS > 1) ? clog2(N_KEYS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    ps2_key_tracker_if.slave   bus
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? clog2(TIMEOUT_CYC) : 1;

    state_e            r_state, w_state_d;
    logic [2:0]        r_skip, w_skip_d;
    logic [TW-1:0]     r_tmo, w_tmo_d;
    logic [N_KEYS-1:0] r_key_down, w_key_down_d;
    logic              r_any_down;
    logic              r_evt_valid, r_evt_ext, r_evt_break, r_evt_hit, r_evt_repeat;
    logic [7:0]        r_evt_code;
    logic [IDXW-1:0]   r_evt_idx;
    logic              r_err_tick;

    logic              w_emit, w_ext, w_brk, w_abort, w_pfx;
    logic              w_hit, w_repeat;
    logic [IDXW-1:0]   w_idx;

    // Table lookup uses the extended flag implied by the current state
    assign w_ext = (r_state == StE0) || (r_state == StE0F0);
    assign w_pfx = (r_state == StE0) || (r_state == StF0) || (r_state == StE0F0);

    ps2_key_lut #(
        .N_KEYS    (N_KEYS),
        .KEY_CODES (KEY_CODES),
        .IDXW      (IDXW)
    ) u_lut (
        .i_ext  (w_ext),
        .i_code (bus.din),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    // Next-state decode, event qualification and prefix timeout
    always_comb begin
        w_state_d = r_state;
        w_skip_d  = r_skip;
        w_tmo_d   = '0;
        w_emit    = 1'b0;
        w_brk     = 1'b0;
        w_abort   = 1'b0;
        if (bus.rx_done_tick) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.din == PS2_E0) begin
                        w_state_d = StE0;
                    end else if (bus.din == PS2_F0) begin
                        w_state_d = StF0;
                    end else if (bus.din == PS2_E1) begin
                        w_state_d = StSkip;
                        w_skip_d  = PAUSE_SKIP;
                    end else if (!is_ignored(bus.din)) begin
                        w_emit = 1'b1;
                    end
                end
                StE0: begin
                    if (bus.din == PS2_F0) begin
                        w_state_d = StE0F0;
                    end else if ((bus.din != PS2_E0) && (bus.din != PS2_E1)) begin
                        w_emit    = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                StF0, StE0F0: begin
                    w_emit    = 1'b1;
                    w_brk     = 1'b1;
                    w_state_d = StIdle;
                end
                StSkip: begin
                    if (r_skip == 3'd1) begin
                        w_state_d = StIdle;
                    end else begin
                        w_skip_d = r_skip - 3'd1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (w_pfx) begin
            // A byte arriving on the expiry cycle takes the branch above instead
            if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                w_abort   = 1'b1;
                w_state_d = StIdle;
            end else begin
                w_tmo_d = r_tmo + 1'b1;
            end
        end
    end

    // Held-key update; clear_all overrides any make in the same cycle
    always_comb begin
        w_key_down_d = r_key_down;
        w_repeat     = w_emit && w_hit && !w_brk && r_key_down[w_idx];
        if (w_emit && w_hit) begin
            w_key_down_d[w_idx] = !w_brk;
        end
        if (bus.clear_all) begin
            w_key_down_d = '0;
        end
    end

    // State, counters, key levels and event register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_skip       <= '0;
            r_tmo        <= '0;
            r_key_down   <= '0;
            r_any_down   <= 1'b0;
            r_evt_valid  <= 1'b0;
            r_evt_code   <= '0;
            r_evt_ext    <= 1'b0;
            r_evt_break  <= 1'b0;
            r_evt_hit    <= 1'b0;
            r_evt_idx    <= '0;
            r_evt_repeat <= 1'b0;
            r_err_tick   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_skip      <= w_skip_d;
            r_tmo       <= w_tmo_d;
            r_key_down  <= w_key_down_d;
            r_any_down  <= |w_key_down_d;
            r_evt_valid <= w_emit;
            r_err_tick  <= w_abort;
            if (w_emit) begin
                r_evt_code   <= bus.din;
                r_evt_ext    <= w_ext;
                r_evt_break  <= w_brk;
                r_evt_hit    <= w_hit;
                r_evt_idx    <= w_idx;
                r_evt_repeat <= w_repeat;
            end
        end
    end

    assign bus.key_down   = r_key_down;
    assign bus.any_down   = r_any_down;
    assign bus.evt_valid  = r_evt_valid;
    assign bus.evt_code   = r_evt_code;
    assign bus.evt_ext    = r_evt_ext;
    assign bus.evt_break  = r_evt_break;
    assign bus.evt_hit    = r_evt_hit;
    assign bus.evt_idx    = r_evt_idx;
    assign bus.evt_repeat = r_evt_repeat;
    assign bus.err_tick   = r_err_tick;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed, table-driven bench for ps2_key_tracker.
module tb_ps2_key_tracker;

    localparam int unsigned T = 16;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    ps2_key_tracker_if #(.N_KEYS(4), .IDXW(2)) bus ();

    ps2_key_tracker #(
        .N_KEYS      (4),
        .KEY_CODES   ({9'h033, 9'h016, 9'h045, 9'h02C}),
        .TIMEOUT_CYC (T),
        .IDXW        (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       clr;
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       hit;
        logic [1:0] idx;
        logic       rep;
        logic [3:0] kd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] din, input logic clr, input logic valid,
                                input logic ext, input logic brk, input logic hit,
                                input logic [1:0] idx, input logic rep, input logic [3:0] kd);
        vec_t v;
        v.din = din; v.clr = clr; v.valid = valid; v.code = din; v.ext = ext;
        v.brk = brk; v.hit = hit; v.idx = idx; v.rep = rep; v.kd = kd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else n_pass++;
    endtask

    // Present one byte for one cycle; returns #1 after the edge that consumed it
    task automatic send(input logic [7:0] b, input logic clr);
        @(posedge clk); #1;
        bus.din = b; bus.rx_done_tick = 1'b1; bus.clear_all = clr;
        @(posedge clk); #1;
        bus.rx_done_tick = 1'b0; bus.clear_all = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        string s;
        s = $sformatf("v%0d", i);
        chk({s, ".valid"}, 32'(bus.evt_valid), 32'(v.valid));
        if (v.valid) begin
            chk({s, ".code"}, 32'(bus.evt_code), 32'(v.code));
            chk({s, ".ext"}, 32'(bus.evt_ext), 32'(v.ext));
            chk({s, ".brk"}, 32'(bus.evt_break), 32'(v.brk));
            chk({s, ".hit"}, 32'(bus.evt_hit), 32'(v.hit));
            chk({s, ".idx"}, 32'(bus.evt_idx), 32'(v.idx));
            chk({s, ".rep"}, 32'(bus.evt_repeat), 32'(v.rep));
        end
        chk({s, ".kd"}, 32'(bus.key_down), 32'(v.kd));
        chk({s, ".any"}, 32'(bus.any_down), 32'(v.kd != 4'b0));
        chk({s, ".err"}, 32'(bus.err_tick), 32'(0));
    endtask

    initial begin
        int errs;
        int first;
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.din = 8'h00;
        bus.rx_done_tick = 1'b0;
        bus.clear_all = 1'b0;

        //            din    clr valid ext brk hit idx rep kd
        vecs.push_back(mk(8'h2C, 0, 1, 0, 0, 1, 0, 0, 4'b0001)); // plain make key 0
        vecs.push_back(mk(8'h2C, 0, 1, 0, 0, 1, 0, 1, 4'b0001)); // typematic
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 4'b0001));
        vecs.push_back(mk(8'h2C, 0, 1, 0, 1, 1, 0, 0, 4'b0000)); // break key 0
        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'h2C, 0, 1, 1, 0, 0, 0, 0, 4'b0000)); // ext make, no match
        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'h2C, 0, 1, 1, 1, 0, 0, 0, 4'b0000)); // ext break
        vecs.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // ignored response
        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // repeated E0 stays
        vecs.push_back(mk(8'h45, 0, 1, 1, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'hE1, 0, 0, 0, 0, 0, 0, 0, 4'b0000)); // pause sequence
        vecs.push_back(mk(8'h14, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'h77, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'hE1, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'h14, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'h77, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(8'h45, 0, 1, 0, 0, 1, 1, 0, 4'b0010)); // make key 1 after pause
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 4'b0010));
        vecs.push_back(mk(8'h16, 0, 1, 0, 1, 1, 2, 0, 4'b0010)); // break of key not down
        vecs.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 0, 0, 4'b0010));
        vecs.push_back(mk(8'h45, 0, 1, 0, 1, 1, 1, 0, 4'b0000));
        vecs.push_back(mk(8'h2C, 0, 1, 0, 0, 1, 0, 0, 4'b0001));
        vecs.push_back(mk(8'h33, 0, 1, 0, 0, 1, 3, 0, 4'b1001));
        vecs.push_back(mk(8'h45, 1, 1, 0, 0, 1, 1, 0, 4'b0000)); // clear_all beats make

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.kd", 32'(bus.key_down), 32'(0));
        chk("rst.any", 32'(bus.any_down), 32'(0));
        chk("rst.valid", 32'(bus.evt_valid), 32'(0));
        chk("rst.err", 32'(bus.err_tick), 32'(0));

        foreach (vecs[i]) begin
            send(vecs[i].din, vecs[i].clr);
            check_vec(i, vecs[i]);
        end

        // Prefix timeout: F0 then silence; abort lands T cycles after the byte
        send(8'hF0, 1'b0);
        errs = 0;
        first = -1;
        for (int i = 1; i <= int'(T) + 4; i++) begin
            @(posedge clk); #1;
            if (bus.err_tick) begin
                errs++;
                if (first < 0) first = i;
            end
            if (bus.evt_valid) errs += 100;
        end
        chk("tmo.count", 32'(errs), 32'(1));
        chk("tmo.when", 32'(first), 32'(T));
        send(8'h16, 1'b0);
        chk("tmo.valid", 32'(bus.evt_valid), 32'(1));
        chk("tmo.brk", 32'(bus.evt_break), 32'(0));
        chk("tmo.idx", 32'(bus.evt_idx), 32'(2));
        chk("tmo.kd", 32'(bus.key_down), 32'(4'b0100));

        // Byte arriving on the expiry cycle wins over the abort
        send(8'hF0, 1'b0);
        repeat (T - 2) @(posedge clk);
        send(8'h16, 1'b0);
        chk("race.err", 32'(bus.err_tick), 32'(0));
        chk("race.valid", 32'(bus.evt_valid), 32'(1));
        chk("race.brk", 32'(bus.evt_break), 32'(1));
        chk("race.kd", 32'(bus.key_down), 32'(0));

        // Reset in the middle of E0 F0 discards the sequence and the held keys
        send(8'h2C, 1'b0);
        chk("mid.kd", 32'(bus.key_down), 32'(4'b0001));
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        pulse_reset();
        chk("rst2.kd", 32'(bus.key_down), 32'(0));
        chk("rst2.any", 32'(bus.any_down), 32'(0));
        chk("rst2.valid", 32'(bus.evt_valid), 32'(0));
        send(8'h2C, 1'b0);
        chk("rst2.ext", 32'(bus.evt_ext), 32'(0));
        chk("rst2.brk", 32'(bus.evt_break), 32'(0));
        chk("rst2.kd2", 32'(bus.key_down), 32'(4'b0001));
        @(posedge clk); #1;
        chk("rst2.pulse", 32'(bus.evt_valid), 32'(0));
        chk("rst2.hold", 32'(bus.evt_code), 32'(8'h2C));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
